uart_tx_arb: RTL and testbench

- Round-robin arbiter that shares the single UART print channel (the `uart_top` TX strobe/busy interface) among up to four requesters.
- Each requester owns a one-deep holding slot.
- The arbiter sequences one print transaction at a time and tags it with the requester index, driven on the register-ID field so the printed line identifies its source ("R<n>:<hex>").
- It sits between the sequencer datapath ports and `uart_top`.

---
 rtl/uart_tx_arb_if.sv | 28 ++
 rtl/uart_tx_arb.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arb.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
// Requester-side and UART-side handshake bundle for the print-channel arbiter.
// master is the arbiter's view; slave is the surrounding datapath/UART view.
interface uart_tx_arb_if #(
  parameter int DP_WIDTH = 8,
  parameter int N_REQ    = 4
);
  logic [N_REQ-1:0]          req_stb;
  logic [N_REQ*DP_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]          req_pend;
  logic [N_REQ-1:0]          req_ovf;
  logic                      ovf_clr;
  logic                      tx_stb;
  logic [DP_WIDTH-1:0]       tx_data;
  logic [1:0]                tx_reg;
  logic                      tx_busy;
  logic                      tx_timeout;
  logic                      idle;

  modport master (
    input  req_stb, req_data, ovf_clr, tx_busy,
    output req_pend, req_ovf, tx_stb, tx_data, tx_reg, tx_timeout, idle
  );

  modport slave (
    output req_stb, req_data, ovf_clr, tx_busy,
    input  req_pend, req_ovf, tx_stb, tx_data, tx_reg, tx_timeout, idle
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART print channel among N_REQ requesters,
// each with a one-deep holding slot; the grant index is printed as the register tag.
module uart_tx_arb_slot #(
  parameter int DP_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stb,
  input  logic [DP_WIDTH-1:0] data,
  input  logic                grant,
  input  logic                ovf_clr,
  output logic                pend,
  output logic [DP_WIDTH-1:0] q,
  output logic                ovf
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      q    <= '0;
      ovf  <= 1'b0;
    end else begin
      // a grant frees the slot in the same edge, so a coincident strobe is accepted
      if (stb && (!pend || grant)) begin
        pend <= 1'b1;
        q    <= data;
      end else if (grant) begin
        pend <= 1'b0;
      end
      if (stb && pend && !grant) ovf <= 1'b1;
      else if (ovf_clr)          ovf <= 1'b0;
    end
  end
endmodule

module uart_tx_arb #(
  parameter int DP_WIDTH    = 8,
  parameter int N_REQ       = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input logic           clk,
  input logic           rst,
  uart_tx_arb_if.master bus
);
  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

  state_t                           state, state_n;
  logic [N_REQ-1:0][DP_WIDTH-1:0]   req_data_a;
  logic [N_REQ-1:0][DP_WIDTH-1:0]   slot_q;
  logic [N_REQ-1:0]                 pend, ovf, grant_vec;
  logic [1:0]                       last, sel;
  logic [DP_WIDTH-1:0]              sel_data;
  logic                             sel_vld, grant, to_evt;
  logic [CW-1:0]                    cnt;
  logic                             tx_stb_q, timeout_q;
  logic [DP_WIDTH-1:0]              tx_data_q;
  logic [1:0]                       tx_reg_q;

  assign req_data_a = bus.req_data;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    uart_tx_arb_slot #(.DP_WIDTH(DP_WIDTH)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .stb     (bus.req_stb[g]),
      .data    (req_data_a[g]),
      .grant   (grant_vec[g]),
      .ovf_clr (bus.ovf_clr),
      .pend    (pend[g]),
      .q       (slot_q[g]),
      .ovf     (ovf[g])
    );
  end

  // Rotating priority: indices above last first, then wrap to 0..last.
  always_comb begin
    sel      = '0;
    sel_vld  = 1'b0;
    sel_data = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!sel_vld && pend[j] && (j > int'(last))) begin
        sel_vld  = 1'b1;
        sel      = 2'(j);
        sel_data = slot_q[j];
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!sel_vld && pend[j] && (j <= int'(last))) begin
        sel_vld  = 1'b1;
        sel      = 2'(j);
        sel_data = slot_q[j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    grant     = 1'b0;
    to_evt    = 1'b0;
    grant_vec = '0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          grant   = 1'b1;
          state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_n = WAIT_DONE;
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          to_evt  = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    for (int j = 0; j < N_REQ; j++) grant_vec[j] = grant && (sel == 2'(j));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_stb_q  <= 1'b0;
      tx_data_q <= '0;
      tx_reg_q  <= '0;
      last      <= 2'(N_REQ - 1);
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      tx_stb_q <= grant;
      if (grant) begin
        tx_data_q <= sel_data;
        tx_reg_q  <= sel;
        last      <= sel;
        cnt       <= '0;
      end else if (state == WAIT_ACK && !bus.tx_busy) begin
        cnt <= cnt + CW'(1);
      end
      if (to_evt)           timeout_q <= 1'b1;
      else if (bus.ovf_clr) timeout_q <= 1'b0;
    end
  end

  assign bus.req_pend   = pend;
  assign bus.req_ovf    = ovf;
  assign bus.tx_stb     = tx_stb_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_reg     = tx_reg_q;
  assign bus.tx_timeout = timeout_q;
  assign bus.idle       = (state == IDLE) && !(|pend);
endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: stimulus pushes expected (tag, data) prints,
// a monitor pops and compares on every tx strobe; a simple UART model drives busy.
module tb_uart_tx_arb;
  logic clk, rst;
  int   n_chk, n_fail;
  int   busy_len;
  bit   busy_en;

  typedef struct packed {
    logic [1:0] r;
    logic [7:0] d;
  } exp_t;
  exp_t exp_q[$];

  uart_tx_arb_if #(.DP_WIDTH(8), .N_REQ(4)) bus ();

  uart_tx_arb #(.DP_WIDTH(8), .N_REQ(4), .ACK_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [1:0] r, input logic [7:0] d);
    exp_q.push_back(exp_t'({r, d}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] m, input logic [31:0] d);
    bus.req_stb  = m;
    bus.req_data = d;
    tick();
    bus.req_stb  = '0;
  endtask

  task automatic wait_stb(input int bound);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.tx_stb && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("stb_seen", 32'(bus.tx_stb), 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.idle && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", 32'(bus.idle), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pend"},    32'(bus.req_pend),   32'd0);
    chk({tag, "_ovf"},     32'(bus.req_ovf),    32'd0);
    chk({tag, "_stb"},     32'(bus.tx_stb),     32'd0);
    chk({tag, "_data"},    32'(bus.tx_data),    32'd0);
    chk({tag, "_reg"},     32'(bus.tx_reg),     32'd0);
    chk({tag, "_timeout"}, 32'(bus.tx_timeout), 32'd0);
    chk({tag, "_idle"},    32'(bus.idle),       32'd1);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  // UART model: busy rises the cycle after a strobe and stays high busy_len cycles
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.tx_stb && busy_en) begin
        @(posedge clk);
        #1 bus.tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 bus.tx_busy = 1'b0;
      end
    end
  end

  // Monitor: every strobe must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.tx_stb) begin
        if (exp_q.size() == 0) begin
          chk("spurious_stb", 32'(bus.tx_stb), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("tx_reg",       32'(bus.tx_reg),  32'(e.r));
          chk("tx_data",      32'(bus.tx_data), 32'(e.d));
          chk("stb_busy_low", 32'(bus.tx_busy), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    busy_len = 18;
    busy_en = 1'b1;
    rst = 1'b1;
    bus.req_stb = '0;
    bus.req_data = '0;
    bus.ovf_clr = 1'b0;
    apply_reset();

    // single request: pend at cycle 1, strobe at cycle 2
    push(2'd2, 8'h5A);
    strobe(4'b0100, 32'h005A_0000);
    @(negedge clk);
    chk("single_pend", 32'(bus.req_pend), 32'h4);
    @(negedge clk);
    chk("single_lat_stb", 32'(bus.tx_stb),  32'd1);
    chk("single_lat_reg", 32'(bus.tx_reg),  32'd2);
    chk("single_lat_dat", 32'(bus.tx_data), 32'h5A);
    wait_idle(60);

    // simultaneous: rotation from reset order 0,1,2,3
    apply_reset();
    push(2'd0, 8'h11); push(2'd1, 8'h22); push(2'd2, 8'h33); push(2'd3, 8'h44);
    strobe(4'b1111, 32'h4433_2211);
    wait_idle(200);
    chk("simul_pend", 32'(bus.req_pend), 32'd0);
    chk("simul_ovf",  32'(bus.req_ovf),  32'd0);

    // overflow: second strobe to pending slot 1 is dropped
    push(2'd0, 8'hA0);
    strobe(4'b0001, 32'h0000_00A0);
    wait_stb(10);
    tick(); tick();
    push(2'd1, 8'h01);
    strobe(4'b0010, 32'h0000_0100);
    tick();
    strobe(4'b0010, 32'h0000_FF00);
    @(negedge clk);
    chk("ovf_set",  32'(bus.req_ovf),  32'h2);
    chk("ovf_pend", 32'(bus.req_pend), 32'h2);
    @(posedge clk);
    #1 bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clr", 32'(bus.req_ovf), 32'd0);
    wait_idle(100);

    // fairness: 3, then {0,3}->0, {0,3}->3, {0,1}->0, then 1
    push(2'd3, 8'hC3);
    strobe(4'b1000, 32'hC300_0000);
    wait_stb(10);
    tick(); tick();
    push(2'd0, 8'hC0); push(2'd3, 8'hD3);
    strobe(4'b1001, 32'hD300_00C0);
    wait_stb(40);
    tick(); tick();
    push(2'd0, 8'hE0);
    strobe(4'b0001, 32'h0000_00E0);
    wait_stb(40);
    tick(); tick();
    push(2'd1, 8'hB1);
    strobe(4'b0010, 32'h0000_B100);
    wait_idle(200);

    // timeout: no busy; back to IDLE 4 cycles after strobe, next slot granted
    busy_en = 1'b0;
    push(2'd2, 8'h77); push(2'd3, 8'h88);
    strobe(4'b1100, 32'h8877_0000);
    wait_stb(10);
    repeat (3) @(negedge clk);
    chk("to_not_yet", 32'(bus.tx_timeout), 32'd0);
    @(negedge clk);
    chk("to_set", 32'(bus.tx_timeout), 32'd1);
    @(negedge clk);
    chk("to_regrant", 32'(bus.tx_stb), 32'd1);
    wait_idle(20);
    busy_en = 1'b1;
    @(posedge clk);
    #1 bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    @(negedge clk);
    chk("to_clr", 32'(bus.tx_timeout), 32'd0);

    // reset in WAIT_DONE with slots 1 and 2 pending
    push(2'd0, 8'h10);
    strobe(4'b0001, 32'h0000_0010);
    wait_stb(10);
    tick(); tick();
    strobe(4'b0110, 32'h0033_2200);
    @(negedge clk);
    chk("midrst_pend_before", 32'(bus.req_pend), 32'h6);
    #1 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_pend", 32'(bus.req_pend), 32'd0);
    @(posedge clk);
    #1;
    push(2'd3, 8'h99);
    strobe(4'b1000, 32'h9900_0000);
    wait_idle(60);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
